// File: rtl/bitorder_nibble_swap_pkg.sv
// Shared helpers for the chunk-order reverser: byte geometry derived from chunk width.
package bitorder_nibble_swap_pkg;

    function automatic int chunks_per_byte(input int n);
        return 8 / n;
    endfunction

    // Index width never collapses to zero so K=1 still gets a legal vector.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/bitorder_chunk_buffer.sv
// One byte's worth of chunk storage: indexed write from the fill side, indexed read for draining.
module bitorder_chunk_buffer #(
    parameter int N  = 2,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic [N-1:0]  rdata_o
);

    localparam int DEPTH = 1 << IW;

    logic [N-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/bitorder_nibble_swap.sv
// Streaming reverser: emits each complete byte's chunks MS-chunk first, gap-free across bytes.
module bitorder_nibble_swap
    import bitorder_nibble_swap_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] axiid,
    input  logic         axiiv,
    output logic         axiov,
    output logic [N-1:0] axiod
);

    localparam int            K    = chunks_per_byte(N);
    localparam int            IW   = idx_width(K);
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] drain_q, drain_d;
    logic          sel_q, sel_d;
    logic          axiov_q, axiov_d;
    logic [N-1:0]  axiod_q, axiod_d;

    logic          complete;
    logic          fill_we;
    logic [IW-1:0] ridx;
    logic [1:0]    we;
    logic [N-1:0]  rdata [2];

    // The last chunk bypasses storage and goes straight to the output register.
    assign complete = axiiv && (cnt_q == LAST);
    assign fill_we  = axiiv && (cnt_q != LAST);
    assign we[0]    = fill_we && !sel_q;
    assign we[1]    = fill_we &&  sel_q;
    assign ridx     = drain_q - IW'(1);

    generate
        for (genvar b = 0; b < 2; b++) begin : g_buf
            bitorder_chunk_buffer #(
                .N  (N),
                .IW (IW)
            ) u_buf (
                .clk     (clk),
                .rst     (rst),
                .we_i    (we[b]),
                .widx_i  (cnt_q),
                .wdata_i (axiid),
                .ridx_i  (ridx),
                .rdata_o (rdata[b])
            );
        end
    endgenerate

    always_comb begin
        cnt_d   = '0;
        sel_d   = sel_q;
        drain_d = drain_q;
        axiov_d = 1'b0;
        axiod_d = '0;
        if (axiiv) cnt_d = complete ? '0 : cnt_q + IW'(1);
        // A completion can never overlap a drain: the previous byte finishes one edge earlier.
        if (complete) begin
            sel_d   = ~sel_q;
            drain_d = LAST;
            axiov_d = 1'b1;
            axiod_d = axiid;
        end else if (drain_q != '0) begin
            drain_d = drain_q - IW'(1);
            axiov_d = 1'b1;
            axiod_d = sel_q ? rdata[0] : rdata[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            drain_q <= '0;
            sel_q   <= 1'b0;
            axiov_q <= 1'b0;
            axiod_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            sel_q   <= sel_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule

// File: tb/tb_bitorder_nibble_swap.sv
// Bench for the chunk-order reverser: N=4 instance against a queue model, plus an N=2 instance.
module tb_bitorder_nibble_swap;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] axiid;
    logic       axiiv;
    logic       axiov;
    logic [3:0] axiod;
    logic [1:0] axiid2;
    logic       axiiv2;
    logic       axiov2;
    logic [1:0] axiod2;

    int checks = 0;
    int errors = 0;

    logic [3:0] sbq [$];
    logic [3:0] part [$];
    logic       exp_v;
    logic [3:0] exp_d;

    bitorder_nibble_swap #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .axiid (axiid),
        .axiiv (axiiv),
        .axiov (axiov),
        .axiod (axiod)
    );

    bitorder_nibble_swap #(.N(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .axiid (axiid2),
        .axiiv (axiiv2),
        .axiov (axiov2),
        .axiod (axiod2)
    );

    always #5 clk = ~clk;

    // Drives one cycle, updates the model on the edge, returns at the following negedge.
    task automatic step(input logic v, input logic [3:0] d);
        axiiv = v;
        axiid = d;
        @(posedge clk);
        if (v) begin
            part.push_back(d);
            if (part.size() == 2) begin
                sbq.push_back(part[1]);
                sbq.push_back(part[0]);
                part.delete();
            end
        end else begin
            part.delete();
        end
        if (sbq.size() > 0) begin
            exp_v = 1'b1;
            exp_d = sbq.pop_front();
        end else begin
            exp_v = 1'b0;
            exp_d = 4'h0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; axiiv = 1'b0; axiid = '0; axiiv2 = 1'b0; axiid2 = '0;
        sbq.delete(); part.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (axiov !== 1'b0 || axiod !== 4'h0 || axiov2 !== 1'b0 || axiod2 !== 2'b00) begin
            errors++;
            $display("FAIL reset got v=%b d=%h v2=%b d2=%b want all zero", axiov, axiod, axiov2, axiod2);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL idle[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [4:0] seq [5];
        seq = '{5'h15, 5'h17, 5'h00, 5'h00, 5'h00};
        for (int i = 0; i < 5; i++) begin
            step(seq[i][4], seq[i][3:0]);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL single[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] seq [8];
        seq = '{5'h15, 5'h1D, 5'h11, 5'h1A, 5'h1C, 5'h1D, 5'h00, 5'h00};
        for (int i = 0; i < 8; i++) begin
            step(seq[i][4], seq[i][3:0]);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL b2b[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_partial_byte();
        logic [4:0] seq [6];
        seq = '{5'h15, 5'h1D, 5'h14, 5'h00, 5'h00, 5'h00};
        for (int i = 0; i < 6; i++) begin
            step(seq[i][4], seq[i][3:0]);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL partial[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_gap();
        logic [4:0] seq [7];
        seq = '{5'h15, 5'h00, 5'h13, 5'h19, 5'h00, 5'h00, 5'h00};
        for (int i = 0; i < 7; i++) begin
            step(seq[i][4], seq[i][3:0]);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL gap[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        step(1'b1, 4'h5);
        step(1'b1, 4'hD);
        checks++;
        if (axiov !== 1'b1 || axiod !== 4'hD) begin
            errors++;
            $display("FAIL rstdrain_first got v=%b d=%h want v=1 d=d", axiov, axiod);
        end
        rst = 1'b1;
        axiiv = 1'b0;
        #1;
        checks++;
        if (axiov !== 1'b0 || axiod !== 4'h0) begin
            errors++;
            $display("FAIL rstdrain_async got v=%b d=%h want v=0 d=0", axiov, axiod);
        end
        sbq.delete(); part.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0);
            checks++;
            if (axiov !== 1'b0 || axiod !== 4'h0) begin
                errors++;
                $display("FAIL rstdrain_after[%0d] got v=%b d=%h want v=0 d=0", i, axiov, axiod);
            end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [3:0] d;
        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(0, 9) < 8);
            d = 4'($urandom);
            step(v, d);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL random[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0);
            checks++;
            if (axiov !== exp_v || axiod !== exp_d) begin
                errors++;
                $display("FAIL random_tail[%0d] got v=%b d=%h want v=%b d=%h", i, axiov, axiod, exp_v, exp_d);
            end
        end
    endtask

    task automatic test_n2();
        logic [1:0] in2  [4];
        logic [1:0] out2 [4];
        in2  = '{2'b01, 2'b10, 2'b11, 2'b00};
        out2 = '{2'b00, 2'b11, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            axiiv2 = 1'b1;
            axiid2 = in2[i];
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (axiov2 !== 1'b1 || axiod2 !== out2[0]) begin
            errors++;
            $display("FAIL n2[0] got v=%b d=%b want v=1 d=%b", axiov2, axiod2, out2[0]);
        end
        axiiv2 = 1'b0;
        axiid2 = 2'b00;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (axiov2 !== 1'b1 || axiod2 !== out2[i]) begin
                errors++;
                $display("FAIL n2[%0d] got v=%b d=%b want v=1 d=%b", i, axiov2, axiod2, out2[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (axiov2 !== 1'b0 || axiod2 !== 2'b00) begin
            errors++;
            $display("FAIL n2_idle got v=%b d=%b want v=0 d=00", axiov2, axiod2);
        end
    endtask

    initial begin
        rst = 1'b1; axiiv = 1'b0; axiid = '0; axiiv2 = 1'b0; axiid2 = '0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_partial_byte();
        test_gap();
        test_reset_mid_drain();
        test_random();
        test_n2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
